rx_unit_gen: RTL and testbench

Parametrised successor to the NI receive unit. It decodes flits arriving from the router and turns them into writes.
- Data packets become word writes to the SPM with per-lane enables.
- Config packets become config-bus writes.
- IRQ packets and last-data completions become entries in an integrated interrupt FIFO.
- Malformed packets are flagged and discarded.

---
 rtl/rx_unit_gen_pkg.sv | 54 +++++
 rtl/rx_irq_fifo.sv | 77 +++++++
 rtl/rx_unit_gen.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_rx_unit_gen.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_unit_gen_pkg.sv
// rx_unit_gen_pkg
// Shared types and flit-field helpers for the receive unit and its FIFO.
//   pkt_type_e : header type, encoded exactly as payload[FLIT_W-1:FLIT_W-2]
//   state_e    : receive state machine states
//   *_bit / *_msb functions : flit field positions derived from FLIT_W
//
// Flit layout:
//   valid = FLIT_W+2, sop = FLIT_W+1, eop = FLIT_W, payload = [FLIT_W-1:0].
// Header payload:
//   type    = payload[FLIT_W-1:FLIT_W-2]
//   address = payload[FLIT_W-3 -: ADDR_W]
package rx_unit_gen_pkg;

   // The encoding matches the raw header type bits, so decoding is a cast.
   typedef enum logic [1:0] {
      PKT_DATA      = 2'b00,
      PKT_CONFIG    = 2'b01,
      PKT_DATA_LAST = 2'b10,
      PKT_IRQ       = 2'b11
   } pkt_type_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DATA,
      ST_CONFIG,
      ST_IRQ,
      ST_DRAIN
   } state_e;

   function automatic int valid_bit(input int flit_w);
      return flit_w + 2;
   endfunction

   function automatic int sop_bit(input int flit_w);
      return flit_w + 1;
   endfunction

   function automatic int eop_bit(input int flit_w);
      return flit_w;
   endfunction

   function automatic int type_msb(input int flit_w);
      return flit_w - 1;
   endfunction

   function automatic int addr_msb(input int flit_w);
      return flit_w - 3;
   endfunction

   function automatic int addr_lsb(input int flit_w, input int addr_w);
      return flit_w - 2 - addr_w;
   endfunction

endpackage

// File: rtl/rx_irq_fifo.sv
// rx_irq_fifo
// Synchronous FIFO holding interrupt / data-complete notifications.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   push         : write push_data (accepted if not full, or if popping)
//   push_data    : entry to store
//   pop          : remove head entry; ignored when empty
//   dout         : head entry, combinational view of the storage
//   empty, full  : occupancy flags
//   overflow     : sticky; set when a push is dropped
module rx_irq_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 15
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full,
   output logic             overflow
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W:0]   count_reg;
   logic             overflow_reg;
   logic             do_pop;
   logic             do_push;

   assign empty = (count_reg == '0);
   assign full  = (count_reg == (PTR_W+1)'(DEPTH));

   // A pop in the same cycle frees the head slot, so a push while full is
   // still accepted; the freed slot is exactly the one wr_ptr points at.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   assign dout     = mem_reg[rd_ptr_reg];
   assign overflow = overflow_reg;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_reg[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_reg   <= '0;
         wr_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (do_push && !do_pop) begin
            count_reg <= count_reg + 1'b1;
         end else if (do_pop && !do_push) begin
            count_reg <= count_reg - 1'b1;
         end
         if (push && !do_push) begin
            overflow_reg <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/rx_unit_gen.sv
// rx_unit_gen
// Decodes router flits into SPM word writes, config-bus writes and
// interrupt-FIFO entries. Malformed packets raise a one-cycle rx_err.
// Optional build macro: RX_STATS_EN adds saturating pkt_cnt / err_cnt.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   pkt_in          : {valid, sop, eop, payload[FLIT_W-1:0]}
//   spm_addr/en/wr/wdata          : registered SPM write port
//   config_addr/wr/wdata          : registered config-bus write port
//   irq_fifo_pop/dout/empty       : interrupt FIFO read side
//   irq_overflow    : sticky, a FIFO push was dropped
//   rx_err          : one-cycle protocol error pulse
//   pkt_cnt, err_cnt: (RX_STATS_EN only) good packets / error pulses
module rx_unit_gen
   import rx_unit_gen_pkg::*;
#(
   parameter int FLIT_W         = 32,
   parameter int ADDR_W         = 14,
   parameter int FLITS_PER_WORD = 2,
   parameter int IRQ_FIFO_DEPTH = 4
)(
   input  logic                             clk,
   input  logic                             reset,
   input  logic [FLIT_W+2:0]                pkt_in,
   output logic [ADDR_W-1:0]                spm_addr,
   output logic [FLITS_PER_WORD-1:0]        spm_en,
   output logic                             spm_wr,
   output logic [FLIT_W*FLITS_PER_WORD-1:0] spm_wdata,
   output logic [ADDR_W-1:0]                config_addr,
   output logic                             config_wr,
   output logic [FLIT_W-1:0]                config_wdata,
   input  logic                             irq_fifo_pop,
   output logic [ADDR_W:0]                  irq_fifo_dout,
   output logic                             irq_fifo_empty,
   output logic                             irq_overflow,
`ifdef RX_STATS_EN
   output logic [15:0]                      pkt_cnt,
   output logic [15:0]                      err_cnt,
`endif
   output logic                             rx_err
);

   localparam int WORD_W   = FLIT_W * FLITS_PER_WORD;
   localparam int LANE_W   = (FLITS_PER_WORD > 1) ? $clog2(FLITS_PER_WORD) : 1;
   localparam int VALID_B  = valid_bit(FLIT_W);
   localparam int SOP_B    = sop_bit(FLIT_W);
   localparam int EOP_B    = eop_bit(FLIT_W);
   localparam int TYPE_MSB = type_msb(FLIT_W);
   localparam int ADDR_MSB = addr_msb(FLIT_W);

   // Flit fields
   logic              flit_valid;
   logic              flit_sop;
   logic              flit_eop;
   logic [FLIT_W-1:0] payload;
   pkt_type_e         hdr_type;
   logic [ADDR_W-1:0] hdr_addr;

   assign flit_valid = pkt_in[VALID_B];
   assign flit_sop   = pkt_in[SOP_B];
   assign flit_eop   = pkt_in[EOP_B];
   assign payload    = pkt_in[FLIT_W-1:0];
   assign hdr_type   = pkt_type_e'(payload[TYPE_MSB -: 2]);
   assign hdr_addr   = payload[ADDR_MSB -: ADDR_W];

   // Packet context
   state_e              state_reg, state_next;
   logic [ADDR_W-1:0]   base_reg, base_next;
   logic [ADDR_W-1:0]   offset_reg, offset_next;
   logic [LANE_W-1:0]   lane_idx_reg, lane_idx_next;
   logic                last_reg, last_next;
   logic [WORD_W-1:0]   buf_reg, buf_next;

   // Registered outputs
   logic [ADDR_W-1:0]         spm_addr_reg, spm_addr_next;
   logic [FLITS_PER_WORD-1:0] spm_en_reg, spm_en_next;
   logic                      spm_wr_reg, spm_wr_next;
   logic [WORD_W-1:0]         spm_wdata_reg, spm_wdata_next;
   logic [ADDR_W-1:0]         config_addr_reg, config_addr_next;
   logic                      config_wr_reg, config_wr_next;
   logic [FLIT_W-1:0]         config_wdata_reg, config_wdata_next;
   logic                      rx_err_reg, rx_err_next;

   // FIFO interface
   logic              fifo_push;
   logic [ADDR_W:0]   fifo_push_data;
   logic              fifo_full_unused;

   // Lane assembly: the first flit of a word goes to the top lane.
   logic [WORD_W-1:0]         word_fill;
   logic [FLITS_PER_WORD-1:0] partial_en;
   logic                      word_done;

   assign word_done = (int'(lane_idx_reg) == FLITS_PER_WORD - 1);

   genvar gi;
   generate
      for (gi = 0; gi < FLITS_PER_WORD; gi++) begin : g_lane
         assign word_fill[gi*FLIT_W +: FLIT_W] =
            (int'(lane_idx_reg) == FLITS_PER_WORD - 1 - gi) ? payload
                                                            : buf_reg[gi*FLIT_W +: FLIT_W];
         // With lane_idx+1 flits received, the top lane_idx+1 lanes are valid.
         assign partial_en[gi] = (gi >= FLITS_PER_WORD - 1 - int'(lane_idx_reg));
      end
   endgenerate

   // State register and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg        <= ST_IDLE;
         base_reg         <= '0;
         offset_reg       <= '0;
         lane_idx_reg     <= '0;
         last_reg         <= 1'b0;
         buf_reg          <= '0;
         spm_addr_reg     <= '0;
         spm_en_reg       <= '0;
         spm_wr_reg       <= 1'b0;
         spm_wdata_reg    <= '0;
         config_addr_reg  <= '0;
         config_wr_reg    <= 1'b0;
         config_wdata_reg <= '0;
         rx_err_reg       <= 1'b0;
      end else begin
         state_reg        <= state_next;
         base_reg         <= base_next;
         offset_reg       <= offset_next;
         lane_idx_reg     <= lane_idx_next;
         last_reg         <= last_next;
         buf_reg          <= buf_next;
         spm_addr_reg     <= spm_addr_next;
         spm_en_reg       <= spm_en_next;
         spm_wr_reg       <= spm_wr_next;
         spm_wdata_reg    <= spm_wdata_next;
         config_addr_reg  <= config_addr_next;
         config_wr_reg    <= config_wr_next;
         config_wdata_reg <= config_wdata_next;
         rx_err_reg       <= rx_err_next;
      end
   end

   // Next-state logic. A sop flit is always decoded as a header, whatever
   // the current state, which is what aborts a packet in flight.
   always_comb begin
      state_next = state_reg;
      if (flit_valid) begin
         if (flit_sop) begin
            if (flit_eop) begin
               state_next = ST_IDLE;
            end else begin
               case (hdr_type)
                  PKT_DATA, PKT_DATA_LAST: state_next = ST_DATA;
                  PKT_CONFIG:              state_next = ST_CONFIG;
                  default:                 state_next = ST_IRQ;
               endcase
            end
         end else begin
            case (state_reg)
               ST_IDLE: state_next = ST_IDLE;
               ST_IRQ:  state_next = flit_eop ? ST_IDLE : ST_DRAIN;
               default: begin
                  if (flit_eop) begin
                     state_next = ST_IDLE;
                  end
               end
            endcase
         end
      end
   end

   // Output / datapath logic
   always_comb begin
      base_next         = base_reg;
      offset_next       = offset_reg;
      lane_idx_next     = lane_idx_reg;
      last_next         = last_reg;
      buf_next          = buf_reg;
      spm_addr_next     = spm_addr_reg;
      spm_en_next       = spm_en_reg;
      spm_wr_next       = 1'b0;
      spm_wdata_next    = spm_wdata_reg;
      config_addr_next  = config_addr_reg;
      config_wr_next    = 1'b0;
      config_wdata_next = config_wdata_reg;
      rx_err_next       = 1'b0;
      fifo_push         = 1'b0;
      fifo_push_data    = {1'b0, base_reg};

      if (flit_valid) begin
         if (flit_sop) begin
            // Busy state: the partial word in buf_reg is abandoned unwritten.
            if (state_reg != ST_IDLE || flit_eop) begin
               rx_err_next = 1'b1;
            end
            if (!flit_eop) begin
               base_next     = hdr_addr;
               offset_next   = '0;
               lane_idx_next = '0;
               last_next     = (hdr_type == PKT_DATA_LAST);
               buf_next      = '0;
            end
         end else begin
            case (state_reg)
               ST_IDLE: begin
                  rx_err_next = 1'b1;
               end
               ST_DATA: begin
                  if (word_done || flit_eop) begin
                     spm_wr_next    = 1'b1;
                     spm_addr_next  = base_reg + offset_reg;
                     spm_wdata_next = word_fill;
                     spm_en_next    = word_done ? '1 : partial_en;
                     offset_next    = offset_reg + 1'b1;
                     lane_idx_next  = '0;
                     buf_next       = '0;
                  end else begin
                     lane_idx_next = lane_idx_reg + 1'b1;
                     buf_next      = word_fill;
                  end
                  if (flit_eop && last_reg) begin
                     fifo_push      = 1'b1;
                     fifo_push_data = {1'b0, base_reg};
                  end
               end
               ST_CONFIG: begin
                  config_wr_next    = 1'b1;
                  config_addr_next  = base_reg + offset_reg;
                  config_wdata_next = payload;
                  offset_next       = offset_reg + 1'b1;
               end
               ST_IRQ: begin
                  spm_wr_next    = 1'b1;
                  spm_addr_next  = base_reg;
                  spm_en_next    = FLITS_PER_WORD'(1);
                  spm_wdata_next = WORD_W'(payload);
                  fifo_push      = 1'b1;
                  fifo_push_data = {1'b1, base_reg};
                  if (!flit_eop) begin
                     rx_err_next = 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   rx_irq_fifo #(
      .DEPTH (IRQ_FIFO_DEPTH),
      .WIDTH (ADDR_W + 1)
   ) u_irq_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (fifo_push_data),
      .pop       (irq_fifo_pop),
      .dout      (irq_fifo_dout),
      .empty     (irq_fifo_empty),
      .full      (fifo_full_unused),
      .overflow  (irq_overflow)
   );

   assign spm_addr     = spm_addr_reg;
   assign spm_en       = spm_en_reg;
   assign spm_wr       = spm_wr_reg;
   assign spm_wdata    = spm_wdata_reg;
   assign config_addr  = config_addr_reg;
   assign config_wr    = config_wr_reg;
   assign config_wdata = config_wdata_reg;
   assign rx_err       = rx_err_reg;

`ifdef RX_STATS_EN
   logic        pkt_done;
   logic [15:0] pkt_cnt_reg;
   logic [15:0] err_cnt_reg;

   // A packet completes cleanly on a non-sop eop in DATA/CONFIG, or on an
   // IRQ packet whose single payload flit carries eop.
   assign pkt_done = flit_valid && !flit_sop && flit_eop &&
                     (state_reg == ST_DATA || state_reg == ST_CONFIG || state_reg == ST_IRQ);

   always_ff @(posedge clk) begin
      if (reset) begin
         pkt_cnt_reg <= '0;
         err_cnt_reg <= '0;
      end else begin
         if (pkt_done && pkt_cnt_reg != 16'hFFFF) begin
            pkt_cnt_reg <= pkt_cnt_reg + 16'd1;
         end
         if (rx_err_next && err_cnt_reg != 16'hFFFF) begin
            err_cnt_reg <= err_cnt_reg + 16'd1;
         end
      end
   end

   assign pkt_cnt = pkt_cnt_reg;
   assign err_cnt = err_cnt_reg;
`endif

endmodule

// File: tb/tb_rx_unit_gen.sv
// tb_rx_unit_gen
// Directed bench: a table of flit vectors with expected outputs for the
// default configuration, plus hand-written sequences for FIFO fill/overflow,
// reset mid-packet and a FLITS_PER_WORD=4 address-wrap instance.
module tb_rx_unit_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset;
   logic [34:0]  pkt_in;
   logic [34:0]  pkt_in4;
   logic         irq_fifo_pop;
   logic         irq_fifo_pop4;

   logic [13:0]  spm_addr, config_addr;
   logic [1:0]   spm_en;
   logic         spm_wr, config_wr;
   logic [63:0]  spm_wdata;
   logic [31:0]  config_wdata;
   logic [14:0]  irq_fifo_dout;
   logic         irq_fifo_empty, irq_overflow, rx_err;

   logic [13:0]  spm_addr4, config_addr4;
   logic [3:0]   spm_en4;
   logic         spm_wr4, config_wr4;
   logic [127:0] spm_wdata4;
   logic [31:0]  config_wdata4;
   logic [14:0]  irq_fifo_dout4;
   logic         irq_fifo_empty4, irq_overflow4, rx_err4;

   rx_unit_gen dut (
      .clk(clk), .reset(reset), .pkt_in(pkt_in),
      .spm_addr(spm_addr), .spm_en(spm_en), .spm_wr(spm_wr), .spm_wdata(spm_wdata),
      .config_addr(config_addr), .config_wr(config_wr), .config_wdata(config_wdata),
      .irq_fifo_pop(irq_fifo_pop), .irq_fifo_dout(irq_fifo_dout),
      .irq_fifo_empty(irq_fifo_empty), .irq_overflow(irq_overflow), .rx_err(rx_err)
   );

   rx_unit_gen #(.FLITS_PER_WORD(4)) dut4 (
      .clk(clk), .reset(reset), .pkt_in(pkt_in4),
      .spm_addr(spm_addr4), .spm_en(spm_en4), .spm_wr(spm_wr4), .spm_wdata(spm_wdata4),
      .config_addr(config_addr4), .config_wr(config_wr4), .config_wdata(config_wdata4),
      .irq_fifo_pop(irq_fifo_pop4), .irq_fifo_dout(irq_fifo_dout4),
      .irq_fifo_empty(irq_fifo_empty4), .irq_overflow(irq_overflow4), .rx_err(rx_err4)
   );

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [34:0] flit(input logic v, input logic s, input logic e,
                                        input logic [31:0] p);
      return {v, s, e, p};
   endfunction

   function automatic logic [31:0] hdr(input logic [1:0] t, input logic [13:0] a);
      return {t, a, 16'h0000};
   endfunction

   typedef struct {
      string       tag;
      logic [34:0] fl;
      logic        wr;
      logic [13:0] waddr;
      logic [1:0]  wen;
      logic [63:0] wdata;
      logic        cwr;
      logic [13:0] caddr;
      logic [31:0] cdata;
      logic        err;
      logic        fempty;
      logic [14:0] fhead;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input string tag, input logic [34:0] fl,
                               input logic wr, input logic [13:0] wa, input logic [1:0] we,
                               input logic [63:0] wd, input logic cwr, input logic [13:0] ca,
                               input logic [31:0] cd, input logic err, input logic fe,
                               input logic [14:0] fh);
      vec_t v;
      v.tag = tag; v.fl = fl; v.wr = wr; v.waddr = wa; v.wen = we; v.wdata = wd;
      v.cwr = cwr; v.caddr = ca; v.cdata = cd; v.err = err; v.fempty = fe; v.fhead = fh;
      return v;
   endfunction

   task automatic send(input logic [34:0] fl, input logic pop);
      pkt_in = fl;
      irq_fifo_pop = pop;
      @(posedge clk);
      #1;
      pkt_in = '0;
      irq_fifo_pop = 1'b0;
   endtask

   task automatic send4(input logic [34:0] fl);
      pkt_in4 = fl;
      @(posedge clk);
      #1;
      pkt_in4 = '0;
   endtask

   localparam logic [31:0] DA = 32'hA0A0_0001, DB = 32'hB0B0_0002;
   localparam logic [31:0] DC = 32'hC0C0_0003, DD = 32'hD0D0_0004;
   localparam logic [31:0] LE = 32'h1E1E_0005, LF = 32'h1F1F_0006, LG = 32'h1616_0007;
   localparam logic [31:0] C1 = 32'hCF00_0011, C2 = 32'hCF00_0022, C3 = 32'hCF00_0033;
   localparam logic [31:0] H0 = 32'h4848_0008, I1 = 32'h1111_0009;
   localparam logic [31:0] J0 = 32'h2222_000A, K0 = 32'h3333_000B, X0 = 32'h7777_000C;

   initial begin
      logic [31:0] p4 [8];
      logic [14:0] exp_heads [4];

      reset = 1'b1;
      pkt_in = '0;
      pkt_in4 = '0;
      irq_fifo_pop = 1'b0;
      irq_fifo_pop4 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset state
      chk("rst.spm_wr", spm_wr, 1'b0);
      chk("rst.spm_en", spm_en, 2'b00);
      chk("rst.spm_addr", spm_addr, 14'h0);
      chk("rst.spm_wdata", spm_wdata, 64'h0);
      chk("rst.config_wr", config_wr, 1'b0);
      chk("rst.config_addr", config_addr, 14'h0);
      chk("rst.config_wdata", config_wdata, 32'h0);
      chk("rst.fifo_empty", irq_fifo_empty, 1'b1);
      chk("rst.overflow", irq_overflow, 1'b0);
      chk("rst.rx_err", rx_err, 1'b0);

      // Vector table: each row's expectations are the outputs one cycle later.
      vecs.push_back(mk("d_hdr", flit(1,1,0,hdr(2'b00,14'h0100)), 0,0,0,0, 0,0,0, 0, 1,0));
      vecs.push_back(mk("d_A",   flit(1,0,0,DA), 0,0,0,0, 0,0,0, 0, 1,0));
      vecs.push_back(mk("d_B",   flit(1,0,0,DB), 1,14'h0100,2'b11,{DA,DB}, 0,0,0, 0, 1,0));
      vecs.push_back(mk("d_C",   flit(1,0,0,DC), 0,0,0,0, 0,0,0, 0, 1,0));
      vecs.push_back(mk("d_D",   flit(1,0,1,DD), 1,14'h0101,2'b11,{DC,DD}, 0,0,0, 0, 1,0));
      vecs.push_back(mk("idle",  35'h0, 0,0,0,0, 0,0,0, 0, 1,0));
      vecs.push_back(mk("l_hdr", flit(1,1,0,hdr(2'b10,14'h0200)), 0,0,0,0, 0,0,0, 0, 1,0));
      vecs.push_back(mk("l_E",   flit(1,0,0,LE), 0,0,0,0, 0,0,0, 0, 1,0));
      vecs.push_back(mk("l_F",   flit(1,0,0,LF), 1,14'h0200,2'b11,{LE,LF}, 0,0,0, 0, 1,0));
      vecs.push_back(mk("l_G",   flit(1,0,1,LG), 1,14'h0201,2'b10,{LG,32'h0}, 0,0,0, 0, 0,15'h0200));
      vecs.push_back(mk("c_hdr", flit(1,1,0,hdr(2'b01,14'h0010)), 0,0,0,0, 0,0,0, 0, 0,15'h0200));
      vecs.push_back(mk("c_1",   flit(1,0,0,C1), 0,0,0,0, 1,14'h0010,C1, 0, 0,15'h0200));
      vecs.push_back(mk("c_2",   flit(1,0,1,C2), 0,0,0,0, 1,14'h0011,C2, 0, 0,15'h0200));
      vecs.push_back(mk("a_hdr", flit(1,1,0,hdr(2'b00,14'h0300)), 0,0,0,0, 0,0,0, 0, 0,15'h0200));
      vecs.push_back(mk("a_H",   flit(1,0,0,H0), 0,0,0,0, 0,0,0, 0, 0,15'h0200));
      vecs.push_back(mk("a_new", flit(1,1,0,hdr(2'b01,14'h0020)), 0,0,0,0, 0,0,0, 1, 0,15'h0200));
      vecs.push_back(mk("a_c3",  flit(1,0,1,C3), 0,0,0,0, 1,14'h0020,C3, 0, 0,15'h0200));
      vecs.push_back(mk("stray", flit(1,0,1,X0), 0,0,0,0, 0,0,0, 1, 0,15'h0200));
      vecs.push_back(mk("h_eop", flit(1,1,1,hdr(2'b00,14'h0040)), 0,0,0,0, 0,0,0, 1, 0,15'h0200));
      vecs.push_back(mk("i_hdr", flit(1,1,0,hdr(2'b11,14'h0050)), 0,0,0,0, 0,0,0, 0, 0,15'h0200));
      vecs.push_back(mk("i_I1",  flit(1,0,0,I1), 1,14'h0050,2'b01,{32'h0,I1}, 0,0,0, 1, 0,15'h0200));
      vecs.push_back(mk("dr_J",  flit(1,0,0,J0), 0,0,0,0, 0,0,0, 0, 0,15'h0200));
      vecs.push_back(mk("dr_K",  flit(1,0,1,K0), 0,0,0,0, 0,0,0, 0, 0,15'h0200));
      vecs.push_back(mk("post",  flit(1,0,0,X0), 0,0,0,0, 0,0,0, 1, 0,15'h0200));

      for (int i = 0; i < vecs.size(); i++) begin
         send(vecs[i].fl, 1'b0);
         $display("vec %0d %s: spm_wr=%0b cfg_wr=%0b rx_err=%0b", i, vecs[i].tag, spm_wr, config_wr, rx_err);
         chk({vecs[i].tag, ".spm_wr"}, spm_wr, vecs[i].wr);
         chk({vecs[i].tag, ".config_wr"}, config_wr, vecs[i].cwr);
         chk({vecs[i].tag, ".rx_err"}, rx_err, vecs[i].err);
         chk({vecs[i].tag, ".fifo_empty"}, irq_fifo_empty, vecs[i].fempty);
         if (vecs[i].wr) begin
            chk({vecs[i].tag, ".spm_addr"}, spm_addr, vecs[i].waddr);
            chk({vecs[i].tag, ".spm_en"}, spm_en, vecs[i].wen);
            chk({vecs[i].tag, ".spm_wdata"}, spm_wdata, vecs[i].wdata);
         end
         if (vecs[i].cwr) begin
            chk({vecs[i].tag, ".config_addr"}, config_addr, vecs[i].caddr);
            chk({vecs[i].tag, ".config_wdata"}, config_wdata, vecs[i].cdata);
         end
         if (!vecs[i].fempty) begin
            chk({vecs[i].tag, ".fifo_head"}, irq_fifo_dout, vecs[i].fhead);
         end
      end

      // Drain the two queued entries, then pop while empty.
      chk("popA.head0", irq_fifo_dout, 15'h0200);
      send('0, 1'b1);
      $display("pop: empty=%0b head=%0h", irq_fifo_empty, irq_fifo_dout);
      chk("popA.head1", irq_fifo_dout, 15'h4050);
      send('0, 1'b1);
      chk("popA.empty", irq_fifo_empty, 1'b1);
      send('0, 1'b1);
      $display("pop on empty: empty=%0b ovf=%0b", irq_fifo_empty, irq_overflow);
      chk("popA.empty_pop", irq_fifo_empty, 1'b1);
      chk("popA.no_ovf", irq_overflow, 1'b0);

      // Five IRQ packets without pops: fourth fills, fifth overflows.
      for (int k = 0; k < 5; k++) begin
         send(flit(1,1,0,hdr(2'b11, 14'(160 + k))), 1'b0);
         send(flit(1,0,1,32'h1000_0000 + 32'(k)), 1'b0);
         $display("irq %0d: spm_wr=%0b en=%0b ovf=%0b", k, spm_wr, spm_en, irq_overflow);
         chk("irq.spm_wr", spm_wr, 1'b1);
         chk("irq.spm_en", spm_en, 2'b01);
         chk("irq.spm_addr", spm_addr, 14'(160 + k));
         chk("irq.spm_wdata", spm_wdata, {32'h0, 32'h1000_0000 + 32'(k)});
         chk("irq.rx_err", rx_err, 1'b0);
         chk("irq.overflow", irq_overflow, k == 4);
      end
      chk("full.head", irq_fifo_dout, 15'h40A0);

      // Push and pop together while full.
      send(flit(1,1,0,hdr(2'b11, 14'h00A5)), 1'b0);
      send(flit(1,0,1,32'h1000_0005), 1'b1);
      $display("push+pop full: head=%0h ovf=%0b", irq_fifo_dout, irq_overflow);
      chk("pp.overflow", irq_overflow, 1'b1);
      chk("pp.head", irq_fifo_dout, 15'h40A1);
      exp_heads[0] = 15'h40A1;
      exp_heads[1] = 15'h40A2;
      exp_heads[2] = 15'h40A3;
      exp_heads[3] = 15'h40A5;
      for (int k = 0; k < 4; k++) begin
         chk("pp.order", irq_fifo_dout, exp_heads[k]);
         chk("pp.not_empty", irq_fifo_empty, 1'b0);
         send('0, 1'b1);
      end
      chk("pp.empty", irq_fifo_empty, 1'b1);
      chk("pp.overflow_sticky", irq_overflow, 1'b1);

      // Reset in the middle of a last-data packet.
      send(flit(1,1,0,hdr(2'b10, 14'h0400)), 1'b0);
      send(flit(1,0,0,32'h5555_0001), 1'b0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("mid_rst.overflow", irq_overflow, 1'b0);
      send(flit(1,0,1,32'h5555_0002), 1'b0);
      $display("after mid reset: rx_err=%0b spm_wr=%0b empty=%0b", rx_err, spm_wr, irq_fifo_empty);
      chk("mid_rst.rx_err", rx_err, 1'b1);
      chk("mid_rst.spm_wr", spm_wr, 1'b0);
      chk("mid_rst.empty", irq_fifo_empty, 1'b1);

      // FLITS_PER_WORD=4 instance, address wraps past 0x3FFF.
      for (int j = 0; j < 8; j++) p4[j] = 32'hC000_0000 + 32'(j);
      send4(flit(1,1,0,hdr(2'b00, 14'h3FFF)));
      for (int j = 0; j < 8; j++) begin
         send4(flit(1,0,j == 7,p4[j]));
         $display("fpw4 flit %0d: spm_wr=%0b addr=%0h en=%0b", j, spm_wr4, spm_addr4, spm_en4);
         if (j == 3 || j == 7) begin
            chk("fpw4.spm_wr", spm_wr4, 1'b1);
            chk("fpw4.spm_en", spm_en4, 4'b1111);
         end else begin
            chk("fpw4.idle", spm_wr4, 1'b0);
         end
         if (j == 3) begin
            chk("fpw4.addr0", spm_addr4, 14'h3FFF);
            chk("fpw4.data0", spm_wdata4, {p4[0], p4[1], p4[2], p4[3]});
         end
         if (j == 7) begin
            chk("fpw4.addr_wrap", spm_addr4, 14'h0000);
            chk("fpw4.data1", spm_wdata4, {p4[4], p4[5], p4[6], p4[7]});
         end
      end
      chk("fpw4.fifo_empty", irq_fifo_empty4, 1'b1);
      chk("fpw4.rx_err", rx_err4, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
